traffic_conflict_monitor: RTL and testbench

//  Independent safety monitor at the receiving end of the traffic controller's signal interface.

---
 rtl/traffic_pkg.sv | 37 +++
 rtl/traffic_phase_checker.sv | 79 +++++++
 rtl/traffic_conflict_monitor.sv | 132 +++++++++++++
 tb/tb_traffic_conflict_monitor.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/traffic_pkg.sv
// Shared definitions for the traffic conflict monitor: phase codes, fault causes,
// monitor FSM states and the lamp image of a phase code.
package traffic_pkg;

  localparam logic [1:0] PH_RED     = 2'b00;
  localparam logic [1:0] PH_GREEN   = 2'b01;
  localparam logic [1:0] PH_YELLOW  = 2'b10;
  localparam logic [1:0] PH_ILLEGAL = 2'b11;

  localparam logic [2:0] FC_NONE         = 3'd0;
  localparam logic [2:0] FC_CONFLICT     = 3'd1;
  localparam logic [2:0] FC_ILLEGAL      = 3'd2;
  localparam logic [2:0] FC_SEQUENCE     = 3'd3;
  localparam logic [2:0] FC_SHORT_GREEN  = 3'd4;
  localparam logic [2:0] FC_SHORT_YELLOW = 3'd5;
  localparam logic [2:0] FC_SHORT_CLEAR  = 3'd6;
  localparam logic [2:0] FC_LAMP         = 3'd7;

  typedef enum logic {
    ST_MONITOR = 1'b0,
    ST_FAULT   = 1'b1
  } mon_state_e;

  // Lamp triple is packed {red, green, yellow}; an illegal code lights nothing.
  function automatic logic [2:0] lamp_image(input logic [1:0] code);
    logic [2:0] img;
    img = 3'b000;
    case (code)
      PH_RED:    img = 3'b100;
      PH_GREEN:  img = 3'b010;
      PH_YELLOW: img = 3'b001;
      default:   img = 3'b000;
    endcase
    return img;
  endfunction

endpackage

// File: rtl/traffic_phase_checker.sv
// Per-direction phase tracker: previous code, dwell counter and lamp-mismatch run length,
// producing the direction-local violation flags for the monitor.
module traffic_phase_checker
  import traffic_pkg::*;
#(
  parameter int MIN_GREEN_CYC  = 8,
  parameter int MIN_YELLOW_CYC = 3,
  parameter int LAMP_TOL_CYC   = 2,
  parameter int CNT_W          = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             resync,
  input  logic [1:0]       code,
  input  logic [2:0]       lamp,
  output logic             is_red,
  output logic [CNT_W-1:0] red_dwell,
  output logic             go_green,
  output logic             illegal,
  output logic             seq_err,
  output logic             short_green,
  output logic             short_yellow,
  output logic             lamp_err
);

  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] MIN_G    = CNT_W'(MIN_GREEN_CYC);
  localparam logic [CNT_W-1:0] MIN_Y    = CNT_W'(MIN_YELLOW_CYC);
  localparam logic [CNT_W-1:0] LAMP_TOL = CNT_W'(LAMP_TOL_CYC);

  logic [1:0]       prev_q;
  logic [CNT_W-1:0] dwell_q;
  logic [CNT_W-1:0] mm_q;
  logic             changed;
  logic             legal_step;
  logic             mismatch;

  always_comb begin
    changed      = (code != prev_q);
    legal_step   = (prev_q == PH_RED    && code == PH_GREEN)  ||
                   (prev_q == PH_GREEN  && code == PH_YELLOW) ||
                   (prev_q == PH_YELLOW && code == PH_RED);
    is_red       = (code == PH_RED);
    red_dwell    = (prev_q == PH_RED) ? dwell_q : '0;
    go_green     = (prev_q == PH_RED) && (code == PH_GREEN);
    illegal      = (code == PH_ILLEGAL);
    seq_err      = changed && !legal_step;
    short_green  = (prev_q == PH_GREEN)  && (code == PH_YELLOW) && (dwell_q < MIN_G);
    short_yellow = (prev_q == PH_YELLOW) && (code == PH_RED)    && (dwell_q < MIN_Y);
    // An illegal code has no lamp image; it is reported by the illegal check alone.
    mismatch     = !illegal && (lamp != lamp_image(code));
    lamp_err     = mismatch && (mm_q >= LAMP_TOL);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      prev_q  <= PH_RED;
      dwell_q <= CNT_MAX;
      mm_q    <= '0;
    end else if (resync) begin
      prev_q  <= code;
      dwell_q <= CNT_MAX;
      mm_q    <= '0;
    end else begin
      prev_q <= code;
      if (changed) begin
        dwell_q <= CNT_W'(1);
      end else if (dwell_q != CNT_MAX) begin
        dwell_q <= dwell_q + CNT_W'(1);
      end
      if (!mismatch) begin
        mm_q <= '0;
      end else if (mm_q != CNT_MAX) begin
        mm_q <= mm_q + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/traffic_conflict_monitor.sv
// Safety monitor for the NS/EW signal interface: cross-direction checks, first-cause
// priority encoding, sticky FAULT state with flashing-red override request.
module traffic_conflict_monitor
  import traffic_pkg::*;
#(
  parameter int MIN_GREEN_CYC     = 8,
  parameter int MIN_YELLOW_CYC    = 3,
  parameter int MIN_RED_CLEAR_CYC = 2,
  parameter int LAMP_TOL_CYC      = 2,
  parameter int FLASH_HALF_CYC    = 4,
  parameter int CNT_W             = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] ns_code,
  input  logic [1:0] ew_code,
  input  logic       rns,
  input  logic       gns,
  input  logic       yns,
  input  logic       rew,
  input  logic       gew,
  input  logic       yew,
  input  logic       clear_fault,
  output logic       fault,
  output logic [2:0] fault_code,
  output logic       flash_en,
  output logic       flash_lamp,
  output mon_state_e state
);

  localparam logic [CNT_W-1:0] MIN_CLR    = CNT_W'(MIN_RED_CLEAR_CYC);
  localparam logic [CNT_W-1:0] FLASH_LAST = CNT_W'(FLASH_HALF_CYC - 1);

  logic             ns_is_red, ew_is_red, ns_go_green, ew_go_green;
  logic [CNT_W-1:0] ns_red_dwell, ew_red_dwell;
  logic             ns_illegal, ew_illegal, ns_seq, ew_seq;
  logic             ns_sg, ew_sg, ns_sy, ew_sy, ns_lamp, ew_lamp;
  logic             resync;

  traffic_phase_checker #(
    .MIN_GREEN_CYC(MIN_GREEN_CYC), .MIN_YELLOW_CYC(MIN_YELLOW_CYC),
    .LAMP_TOL_CYC(LAMP_TOL_CYC), .CNT_W(CNT_W)
  ) u_ns (
    .clk(clk), .reset(reset), .resync(resync), .code(ns_code), .lamp({rns, gns, yns}),
    .is_red(ns_is_red), .red_dwell(ns_red_dwell), .go_green(ns_go_green),
    .illegal(ns_illegal), .seq_err(ns_seq), .short_green(ns_sg),
    .short_yellow(ns_sy), .lamp_err(ns_lamp)
  );

  traffic_phase_checker #(
    .MIN_GREEN_CYC(MIN_GREEN_CYC), .MIN_YELLOW_CYC(MIN_YELLOW_CYC),
    .LAMP_TOL_CYC(LAMP_TOL_CYC), .CNT_W(CNT_W)
  ) u_ew (
    .clk(clk), .reset(reset), .resync(resync), .code(ew_code), .lamp({rew, gew, yew}),
    .is_red(ew_is_red), .red_dwell(ew_red_dwell), .go_green(ew_go_green),
    .illegal(ew_illegal), .seq_err(ew_seq), .short_green(ew_sg),
    .short_yellow(ew_sy), .lamp_err(ew_lamp)
  );

  logic       conflict, short_clear, clear_ok;
  logic [2:0] cause;

  always_comb begin
    conflict    = !ns_is_red && !ew_is_red;
    short_clear = (ns_go_green && (ew_red_dwell < MIN_CLR)) ||
                  (ew_go_green && (ns_red_dwell < MIN_CLR));
    clear_ok    = clear_fault && (ns_code == PH_RED) && (ew_code == PH_RED);
    cause = FC_NONE;
    if      (conflict)               cause = FC_CONFLICT;
    else if (ns_illegal || ew_illegal) cause = FC_ILLEGAL;
    else if (ns_seq || ew_seq)       cause = FC_SEQUENCE;
    else if (ns_sg || ew_sg)         cause = FC_SHORT_GREEN;
    else if (ns_sy || ew_sy)         cause = FC_SHORT_YELLOW;
    else if (short_clear)            cause = FC_SHORT_CLEAR;
    else if (ns_lamp || ew_lamp)     cause = FC_LAMP;
  end

  mon_state_e state_q, state_d;

  always_comb begin
    state_d = state_q;
    resync  = 1'b0;
    case (state_q)
      ST_MONITOR: if (cause != FC_NONE) state_d = ST_FAULT;
      ST_FAULT: begin
        if (clear_ok) begin
          state_d = ST_MONITOR;
          resync  = 1'b1;
        end
      end
      default: state_d = ST_MONITOR;
    endcase
  end

  logic [2:0]       fault_code_q;
  logic             flash_q;
  logic [CNT_W-1:0] flash_cnt_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_MONITOR;
      fault_code_q <= FC_NONE;
      flash_q      <= 1'b0;
      flash_cnt_q  <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == ST_MONITOR && state_d == ST_FAULT) begin
        fault_code_q <= cause;
        flash_q      <= 1'b1;
        flash_cnt_q  <= '0;
      end else if (state_q == ST_FAULT && state_d == ST_MONITOR) begin
        fault_code_q <= FC_NONE;
        flash_q      <= 1'b0;
        flash_cnt_q  <= '0;
      end else if (state_q == ST_FAULT) begin
        if (flash_cnt_q == FLASH_LAST) begin
          flash_q     <= ~flash_q;
          flash_cnt_q <= '0;
        end else begin
          flash_cnt_q <= flash_cnt_q + CNT_W'(1);
        end
      end
    end
  end

  assign fault      = (state_q == ST_FAULT);
  assign flash_en   = (state_q == ST_FAULT);
  assign fault_code = fault_code_q;
  assign flash_lamp = flash_q;
  assign state      = state_q;

endmodule

// File: tb/tb_traffic_conflict_monitor.sv
// Bench for traffic_conflict_monitor: directed scenarios plus a randomized phase walk,
// all checked against a rule-level reference model through an expected-output queue.
module tb_traffic_conflict_monitor;
  import traffic_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] ns_code, ew_code;
  logic       rns, gns, yns, rew, gew, yew;
  logic       clear_fault;
  logic       fault;
  logic [2:0] fault_code;
  logic       flash_en, flash_lamp;
  mon_state_e state;

  traffic_conflict_monitor dut (
    .clk(clk), .reset(reset), .ns_code(ns_code), .ew_code(ew_code),
    .rns(rns), .gns(gns), .yns(yns), .rew(rew), .gew(gew), .yew(yew),
    .clear_fault(clear_fault), .fault(fault), .fault_code(fault_code),
    .flash_en(flash_en), .flash_lamp(flash_lamp), .state(state)
  );

  // clock / reset
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // {state, fault, fault_code[2:0], flash_en, flash_lamp}
  logic [6:0] exp_q[$];

  // reference model state: per-direction history and monitor status
  int m_prev[2];
  int m_dwell[2];
  int m_mm[2];
  bit m_fault;
  int m_code;
  int m_fcyc;

  task automatic check(input string tag, input int act, input int exp_v);
    n_cmp++;
    if (act != exp_v) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp_v, $time);
    end
  endtask

  function automatic logic [2:0] image(input int c);
    case (c)
      0:       return 3'b100;
      1:       return 3'b010;
      2:       return 3'b001;
      default: return 3'b000;
    endcase
  endfunction

  function automatic int next_phase(input int c);
    case (c)
      0:       return 1;
      1:       return 2;
      default: return 0;
    endcase
  endfunction

  function automatic int pick(input int cause, input bit cond, input int c);
    if (cond && (cause == 0 || c < cause)) return c;
    return cause;
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_prev[d]  = 0;
      m_dwell[d] = 255;
      m_mm[d]    = 0;
    end
    m_fault = 1'b0;
    m_code  = 0;
    m_fcyc  = 0;
  endtask

  task automatic model_step(input int ns, input int ew, input logic [2:0] nl,
                            input logic [2:0] el, input bit clr);
    int         c[2];
    logic [2:0] l[2];
    int         run[2];
    int         cause;
    int         other_red;
    bit         legal;
    bit         flash;
    c[0] = ns; c[1] = ew; l[0] = nl; l[1] = el;
    cause = 0;
    for (int d = 0; d < 2; d++)
      run[d] = (c[d] != 3 && l[d] != image(c[d])) ? m_mm[d] + 1 : 0;
    if (!m_fault) begin
      cause = pick(cause, c[0] != 0 && c[1] != 0, 1);
      cause = pick(cause, c[0] == 3 || c[1] == 3, 2);
      for (int d = 0; d < 2; d++) begin
        other_red = (m_prev[1-d] == 0) ? m_dwell[1-d] : 0;
        if (c[d] != m_prev[d]) begin
          legal = m_prev[d] != 3 && c[d] != 3 && ((m_prev[d] + 1) % 3 == c[d]);
          cause = pick(cause, !legal, 3);
          cause = pick(cause, m_prev[d] == 1 && c[d] == 2 && m_dwell[d] < 8, 4);
          cause = pick(cause, m_prev[d] == 2 && c[d] == 0 && m_dwell[d] < 3, 5);
          cause = pick(cause, m_prev[d] == 0 && c[d] == 1 && other_red < 2, 6);
        end
        cause = pick(cause, run[d] > 2, 7);
      end
      if (cause != 0) begin
        m_fault = 1'b1;
        m_code  = cause;
        m_fcyc  = 0;
      end
    end else if (clr && ns == 0 && ew == 0) begin
      m_fault = 1'b0;
      m_code  = 0;
    end else begin
      m_fcyc++;
    end
    for (int d = 0; d < 2; d++) begin
      if (!m_fault && m_code == 0 && clr && ns == 0 && ew == 0 && cause == 0 &&
          m_prev[d] >= 0 && m_dwell[d] < 0) begin
        m_dwell[d] = 0;
      end
      m_dwell[d] = (c[d] != m_prev[d]) ? 1 : ((m_dwell[d] < 255) ? m_dwell[d] + 1 : 255);
      m_prev[d]  = c[d];
      m_mm[d]    = run[d];
    end
    flash = m_fault && ((m_fcyc / 4) % 2 == 0);
    exp_q.push_back({m_fault, m_fault, 3'(m_code), m_fault, flash});
  endtask

  // a clear that leaves FAULT restarts both directions as freshly reset
  task automatic model_resync_if_cleared(input bit was_fault);
    if (was_fault && !m_fault) begin
      for (int d = 0; d < 2; d++) begin
        m_prev[d]  = 0;
        m_dwell[d] = 255;
        m_mm[d]    = 0;
      end
    end
  endtask

  task automatic compare_outputs();
    logic [6:0] e;
    if (exp_q.size() == 0) begin
      check("exp_q_empty", 1, 0);
      return;
    end
    e = exp_q.pop_front();
    check("state",      int'(state),      int'(e[6]));
    check("fault",      int'(fault),      int'(e[5]));
    check("fault_code", int'(fault_code), int'(e[4:2]));
    check("flash_en",   int'(flash_en),   int'(e[1]));
    check("flash_lamp", int'(flash_lamp), int'(e[0]));
  endtask

  // driver: called at a negedge, returns at the next negedge with outputs checked
  task automatic step(input logic [1:0] ns, input logic [1:0] ew, input logic [2:0] nl,
                      input logic [2:0] el, input logic clr);
    bit was_fault;
    ns_code = ns; ew_code = ew;
    {rns, gns, yns} = nl;
    {rew, gew, yew} = el;
    clear_fault = clr;
    @(posedge clk);
    was_fault = m_fault;
    model_step(int'(ns), int'(ew), nl, el, clr);
    model_resync_if_cleared(was_fault);
    @(negedge clk);
    compare_outputs();
  endtask

  task automatic step_ok(input int ns, input int ew, input logic clr);
    step(2'(ns), 2'(ew), image(ns), image(ew), clr);
  endtask

  task automatic hold(input int ns, input int ew, input int n);
    repeat (n) step_ok(ns, ew, 1'b0);
  endtask

  logic [7:0] pat;
  int         cur_ns, cur_ew;
  logic [2:0] nl, el;

  initial begin
    reset = 1'b0;
    ns_code = 2'b00; ew_code = 2'b00;
    {rns, gns, yns} = 3'b100;
    {rew, gew, yew} = 3'b100;
    clear_fault = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    check("rst_fault",      int'(fault),      0);
    check("rst_fault_code", int'(fault_code), 0);
    check("rst_flash_en",   int'(flash_en),   0);
    check("rst_flash_lamp", int'(flash_lamp), 0);
    reset = 1'b1;

    // legal cycle, three rounds
    repeat (3) begin
      hold(1, 0, 8); hold(2, 0, 3); hold(0, 0, 2);
      hold(0, 1, 8); hold(0, 2, 3); hold(0, 0, 2);
    end
    check("legal_fault", int'(fault), 0);
    check("legal_code",  int'(fault_code), 0);

    // conflict, flash pattern, clear attempts
    pat = 8'b1111_0000;
    step_ok(1, 2, 1'b0);
    check("conflict_code", int'(fault_code), 1);
    check("flash_seq", int'(flash_lamp), int'(pat[7]));
    for (int i = 1; i < 8; i++) begin
      step_ok(1, 2, 1'b0);
      check("flash_seq", int'(flash_lamp), int'(pat[7-i]));
    end
    step_ok(0, 1, 1'b1);
    check("clear_blocked", int'(fault), 1);
    step_ok(0, 0, 1'b1);
    check("clear_fault", int'(fault), 0);
    check("clear_code",  int'(fault_code), 0);
    check("clear_flash", int'(flash_en), 0);

    // short green, then GREEN->RED sequence error
    hold(1, 0, 5);
    step_ok(2, 0, 1'b0);
    check("short_green", int'(fault_code), 4);
    step_ok(0, 0, 1'b1);
    hold(1, 0, 3);
    step_ok(0, 0, 1'b0);
    check("seq_g_to_r", int'(fault_code), 3);
    step_ok(0, 0, 1'b1);

    // lamp mismatch within tolerance, then beyond
    repeat (2) step(2'b00, 2'b00, 3'b010, 3'b100, 1'b0);
    hold(0, 0, 3);
    check("lamp_tol_ok", int'(fault), 0);
    repeat (3) step(2'b00, 2'b00, 3'b010, 3'b100, 1'b0);
    check("lamp_err", int'(fault_code), 7);
    step_ok(0, 0, 1'b1);

    // async reset in FAULT, then immediate NS green
    step_ok(3, 0, 1'b0);
    check("illegal_code", int'(fault_code), 2);
    step_ok(3, 0, 1'b0);
    #2 reset = 1'b0;
    #1;
    check("async_fault",      int'(fault),      0);
    check("async_fault_code", int'(fault_code), 0);
    check("async_flash_en",   int'(flash_en),   0);
    check("async_flash_lamp", int'(flash_lamp), 0);
    model_reset();
    exp_q.delete();
    @(negedge clk);
    reset = 1'b1;
    step_ok(1, 0, 1'b0);
    check("post_rst_green", int'(fault), 0);

    // randomized phase walk
    cur_ns = 1; cur_ew = 0;
    for (int n = 0; n < 2500; n++) begin
      if ($urandom_range(0, 99) < 10) cur_ns = next_phase(cur_ns);
      else if ($urandom_range(0, 99) == 0) cur_ns = $urandom_range(0, 3);
      if ($urandom_range(0, 99) < 10) cur_ew = next_phase(cur_ew);
      else if ($urandom_range(0, 99) == 0) cur_ew = $urandom_range(0, 3);
      if (m_fault && $urandom_range(0, 3) == 0) begin
        cur_ns = 0; cur_ew = 0;
      end
      nl = image(cur_ns);
      el = image(cur_ew);
      if ($urandom_range(0, 24) == 0) nl = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 24) == 0) el = 3'($urandom_range(0, 7));
      step(2'(cur_ns), 2'(cur_ew), nl, el, 1'($urandom_range(0, 2) == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
